dstr_bank: RTL and testbench
============================

DSTR_BANK -- requirements
Module: dstr_bank

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data/address width in bits.
REQ-002 Parameter NCH, default 4, SHALL set the number of independent address channels (NCH >= 2).
REQ-003 Localparam CH_W SHALL equal $clog2(NCH).
REQ-004 clock  in  1  SHALL be the single clock; all state updates occur on its falling edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 cbus_out  in  WIDTH  SHALL be the C-bus write data.
REQ-007 cbus_en  in  4  SHALL be the C-bus destination code.
REQ-008 ch_sel  in  CH_W  SHALL select the channel targeted by C-bus loads.
REQ-009 inc_mask  in  NCH  SHALL select the channels to step this cycle (bit k = channel k).
REQ-010 rd_sel  in  CH_W  SHALL select the channel driven onto abus_in.
REQ-011 abus_in  out  WIDTH  SHALL be the A-bus address of channel rd_sel.
REQ-012 wrap_flag  out  NCH  SHALL be the per-channel one-cycle wrap pulse.

Function
REQ-013 Each channel SHALL hold four WIDTH-bit registers: base, addr, stride, limit.
REQ-014 cbus_en = 4'b1010 SHALL load cbus_out into both base[ch_sel] and addr[ch_sel].
REQ-015 cbus_en = 4'b1011 SHALL load cbus_out into stride[ch_sel].
REQ-016 cbus_en = 4'b1100 SHALL load cbus_out into limit[ch_sel].
REQ-017 Any other cbus_en value SHALL load nothing.
REQ-018 A channel k with inc_mask[k] = 1 SHALL compute next = addr[k] + stride[k] at WIDTH+1 bits.
REQ-019 If next <= limit[k], addr[k] SHALL take next[WIDTH-1:0]; otherwise addr[k] SHALL take base[k] and wrap_flag[k] SHALL be 1 for exactly the following cycle.
REQ-020 wrap_flag[k] SHALL be 0 in every cycle in which channel k did not wrap on the preceding falling edge.
REQ-021 A 4'b1010 load to channel k in the same cycle as inc_mask[k] = 1 SHALL win: addr[k] = cbus_out and no wrap pulse.
REQ-022 A 4'b1011 or 4'b1100 load to channel k in the same cycle as a step of channel k SHALL use the pre-load stride/limit for that step.
REQ-023 Channels not addressed by a load or step SHALL hold their values, and steps on multiple channels in the same cycle SHALL be independent.
REQ-024 abus_in SHALL be combinational from addr[rd_sel], with zero latency after the edge that updates it.
REQ-025 A stride of 0 SHALL leave addr unchanged, with no wrap unless addr > limit.

Reset
REQ-026 While rst = 1, for all channels: addr = 0, base = 0, stride = 1, limit = all-ones, wrap_flag = 0, independent of clock.
REQ-027 abus_in SHALL read 0 during reset.
REQ-028 A reset asserted mid-sequence SHALL discard any pending step or load.
REQ-029 The first falling edge after rst deasserts SHALL process loads and steps normally.

Configuration
REQ-030 With DSTR_WRAP_EN defined, the limit registers, code 4'b1100, and the wrap behaviour of REQ-019/020 SHALL be present.
REQ-031 Without DSTR_WRAP_EN, the limit registers SHALL not exist and code 4'b1100 SHALL be ignored.
REQ-032 Without DSTR_WRAP_EN, steps SHALL be addr + stride modulo 2^WIDTH and wrap_flag SHALL be tied to 0.

Structure
REQ-033 Package dstr_pkg SHALL hold the cbus_en codes (CB_ADDR = 4'b1010, CB_STRIDE = 4'b1011, CB_LIMIT = 4'b1100).
REQ-034 dstr_pkg SHALL also hold the reset constants for stride and limit.
REQ-035 One sub-module dstr_chan (single channel: registers, step/wrap logic, wrap pulse) SHALL be instantiated NCH times by a generate loop.
REQ-036 dstr_bank itself SHALL contain only load decode and the rd_sel multiplexer.

Verification
REQ-037 Reset then rd_sel = 0..3 -> abus_in = 0; after one step on channel 0, abus_in = 1.
REQ-038 Channel 1: load addr 0x100, stride 4, limit 0x10C; 3 steps -> 0x104, 0x108, 0x10C; 4th step -> 0x100 and wrap_flag[1] high for one cycle only.
REQ-039 inc_mask = 4'b0101 with channel 0 stride 2 and channel 2 stride 3, both from 0 -> after 2 cycles ch0 = 4, ch2 = 6, ch1 and ch3 unchanged.
REQ-040 4'b1010 load of 0x55 to channel 3 with inc_mask[3] = 1 in the same cycle -> addr3 = 0x55, wrap_flag[3] = 0.
REQ-041 rst pulsed between clock edges mid-sequence -> all addr = 0 and wrap_flag = 0 immediately, without waiting for an edge.
REQ-042 Without DSTR_WRAP_EN: addr 0xFFFFFFFE, stride 4, one step -> 0x00000002, wrap_flag = 0.

Source files
------------

// File: rtl/dstr_pkg.sv
// dstr_pkg: C-bus destination codes and reset constants for the strided address bank.
package dstr_pkg;
    localparam logic [3:0] CB_ADDR   = 4'b1010;
    localparam logic [3:0] CB_STRIDE = 4'b1011;
    localparam logic [3:0] CB_LIMIT  = 4'b1100;
    localparam int         STRIDE_RST    = 1;
    localparam logic       LIMIT_RST_BIT = 1'b1;
endpackage

// File: rtl/dstr_chan.sv
// dstr_chan: one address channel (base/addr/stride[/limit]) with step, wrap and wrap pulse.
// Limit register and wrap behaviour exist only when DSTR_WRAP_EN is defined.
module dstr_chan
    import dstr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_addr,
    input  logic             ld_stride,
`ifdef DSTR_WRAP_EN
    input  logic             ld_limit,
`endif
    input  logic             inc,
    output logic [WIDTH-1:0] addr,
    output logic             wrap
);
    logic [WIDTH-1:0] base_q, base_d, addr_q, addr_d, stride_q, stride_d;
`ifdef DSTR_WRAP_EN
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   next;
    always_comb begin
        base_d   = base_q;
        stride_d = stride_q;
        limit_d  = limit_q;
        wrap_d   = 1'b0;
        next     = {1'b0, addr_q} + {1'b0, stride_q};
        addr_d   = inc ? ((next <= {1'b0, limit_q}) ? next[WIDTH-1:0] : base_q) : addr_q;
        wrap_d   = inc && (next > {1'b0, limit_q}) && !ld_addr;
        if (ld_stride) stride_d = din;
        if (ld_limit) limit_d = din;
        if (ld_addr) begin
            base_d = din;
            addr_d = din;
        end
    end
    always_ff @(negedge clock or posedge rst) begin
        if (rst) begin
            limit_q <= {WIDTH{LIMIT_RST_BIT}};
            wrap_q  <= 1'b0;
        end else begin
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
        end
    end
    assign wrap = wrap_q;
`else
    always_comb begin
        base_d   = base_q;
        stride_d = stride_q;
        addr_d   = inc ? addr_q + stride_q : addr_q;
        if (ld_stride) stride_d = din;
        if (ld_addr) begin
            base_d = din;
            addr_d = din;
        end
    end
    assign wrap = 1'b0;
`endif
    always_ff @(negedge clock or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            addr_q   <= '0;
            stride_q <= WIDTH'(STRIDE_RST);
        end else begin
            base_q   <= base_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end
    assign addr = addr_q;
endmodule

// File: rtl/dstr_bank.sv
// dstr_bank: NCH strided address channels with C-bus load decode and A-bus read mux.
// Define DSTR_WRAP_EN to enable per-channel limit registers and wrap-to-base.
module dstr_bank
    import dstr_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  NCH   = 4,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] cbus_out,
    input  logic [3:0]       cbus_en,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [NCH-1:0]   inc_mask,
    input  logic [CH_W-1:0]  rd_sel,
    output logic [WIDTH-1:0] abus_in,
    output logic [NCH-1:0]   wrap_flag
);
    logic [WIDTH-1:0] addr_a [NCH];
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic sel;
        assign sel = ch_sel == CH_W'(k);
        dstr_chan #(.WIDTH(WIDTH)) u_chan (
            .clock     (clock),
            .rst       (rst),
            .din       (cbus_out),
            .ld_addr   (sel && cbus_en == CB_ADDR),
            .ld_stride (sel && cbus_en == CB_STRIDE),
`ifdef DSTR_WRAP_EN
            .ld_limit  (sel && cbus_en == CB_LIMIT),
`endif
            .inc       (inc_mask[k]),
            .addr      (addr_a[k]),
            .wrap      (wrap_flag[k])
        );
    end
    assign abus_in = addr_a[rd_sel];
endmodule

// File: tb/tb_dstr_bank.sv
// tb_dstr_bank: directed self-checking bench for dstr_bank (wrap checks under DSTR_WRAP_EN).
module tb_dstr_bank;
    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cbus_out = '0;
    logic [3:0]  cbus_en = '0;
    logic [1:0]  ch_sel = '0;
    logic [3:0]  inc_mask = '0;
    logic [1:0]  rd_sel = '0;
    logic [31:0] abus_in;
    logic [3:0]  wrap_flag;
    int n_tests = 0;
    int n_fail = 0;

    dstr_bank #(.WIDTH(32), .NCH(4)) dut (
        .clock(clock), .rst(rst), .cbus_out(cbus_out), .cbus_en(cbus_en), .ch_sel(ch_sel),
        .inc_mask(inc_mask), .rd_sel(rd_sel), .abus_in(abus_in), .wrap_flag(wrap_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] en, input logic [1:0] sel, input logic [31:0] d, input logic [3:0] m);
        cbus_en = en; ch_sel = sel; cbus_out = d; inc_mask = m;
        @(negedge clock);
        #1;
        cbus_en = 4'b0000; inc_mask = 4'b0000;
    endtask

    task automatic chk_ch(input string tag, input logic [1:0] ch, input logic [31:0] exp);
        rd_sel = ch;
        #1;
        chk(tag, abus_in, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) chk_ch($sformatf("reset_addr%0d", i), 2'(i), 32'h0);
        chk("reset_wrap", {28'h0, wrap_flag}, 32'h0);
        @(negedge clock);
        #1 rst = 1'b0;
        cyc(4'b0000, 2'd0, 32'h0, 4'b0001);
        chk_ch("first_step_ch0", 2'd0, 32'h1);

        do_reset();
        cyc(4'b1011, 2'd0, 32'd2, 4'b0000);
        cyc(4'b1011, 2'd2, 32'd3, 4'b0000);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0101);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0101);
        chk_ch("multi_ch0", 2'd0, 32'd4);
        chk_ch("multi_ch1", 2'd1, 32'd0);
        chk_ch("multi_ch2", 2'd2, 32'd6);
        chk_ch("multi_ch3", 2'd3, 32'd0);

        cyc(4'b1010, 2'd3, 32'h55, 4'b1000);
        chk_ch("load_wins_ch3", 2'd3, 32'h55);
        chk("load_wins_wrap", {28'h0, wrap_flag}, 32'h0);

        cyc(4'b1011, 2'd2, 32'd10, 4'b0100);
        chk_ch("old_stride_step", 2'd2, 32'd9);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0100);
        chk_ch("new_stride_step", 2'd2, 32'd19);

        cyc(4'b0000, 2'd1, 32'h77, 4'b0000);
        cyc(4'b0111, 2'd1, 32'h77, 4'b0000);
        chk_ch("bad_code_noload", 2'd1, 32'd0);

        cyc(4'b1011, 2'd1, 32'd0, 4'b0000);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("stride0_hold", 2'd1, 32'd0);

`ifdef DSTR_WRAP_EN
        cyc(4'b1010, 2'd1, 32'h100, 4'b0000);
        cyc(4'b1011, 2'd1, 32'd4, 4'b0000);
        cyc(4'b1100, 2'd1, 32'h10C, 4'b0000);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("wrap_step1", 2'd1, 32'h104);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("wrap_step2", 2'd1, 32'h108);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("wrap_step3", 2'd1, 32'h10C);
        chk("wrap_flag_pre", {28'h0, wrap_flag}, 32'h0);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("wrap_step4", 2'd1, 32'h100);
        chk("wrap_flag_pulse", {28'h0, wrap_flag}, 32'h2);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0000);
        chk("wrap_flag_clear", {28'h0, wrap_flag}, 32'h0);
`else
        cyc(4'b1010, 2'd1, 32'hFFFF_FFFE, 4'b0000);
        cyc(4'b1011, 2'd1, 32'd4, 4'b0000);
        cyc(4'b1100, 2'd1, 32'h0, 4'b0000);
        cyc(4'b0000, 2'd0, 32'h0, 4'b0010);
        chk_ch("nowrap_modulo", 2'd1, 32'h2);
        chk("nowrap_flag", {28'h0, wrap_flag}, 32'h0);
`endif

        cbus_en = 4'b1010; ch_sel = 2'd0; cbus_out = 32'hABCD; inc_mask = 4'b1111;
        @(posedge clock);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) chk_ch($sformatf("async_rst_addr%0d", i), 2'(i), 32'h0);
        chk("async_rst_wrap", {28'h0, wrap_flag}, 32'h0);
        cbus_en = 4'b0000; inc_mask = 4'b0000;
        @(negedge clock);
        #1;
        chk_ch("rst_discard_load", 2'd0, 32'h0);
        rst = 1'b0;
        cyc(4'b0000, 2'd0, 32'h0, 4'b0001);
        chk_ch("post_rst_step", 2'd0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
